spi_register_bridge: RTL and testbench
======================================

// Module: spi_register_bridge
// PURPOSE
// - SPI slave (mode 0, MSB first) that drives the parallel register bus (_Write, AddressBus, DataIn) feeding the PWM register block.
// - Frame = CS_n low; byte 0 is the target address, every following byte is data written to the register file.
// - Converts asynchronous SPI traffic into clean, CLK-synchronous write strobes with guaranteed setup and hold around the _Write falling edge.
// PARAMETERS
// - AddressWidth  8  width of AddressBus; low AddressWidth bits of the address byte are used (AddressWidth <= 8)
// - BitWidth      8  width of DataIn; fixed at 8 (one SPI byte per register)
// - StrobeCycles  2  CLK cycles _Write is held low per write (>= 1)
// PORTS
// - CLK          in   1             system clock; all logic on the rising edge
// - _RST         in   1             asynchronous active-low reset
// - SCK          in   1             SPI clock, asynchronous to CLK
// - MOSI         in   1             SPI data in, asynchronous to CLK
// - CS_n         in   1             SPI chip select, active low, asynchronous to CLK
// - _Write       out  1             active-low write strobe; registers capture on its falling edge
// - AddressBus   out  AddressWidth  register address for the current write
// - DataIn       out  BitWidth      data for the current write
// - Busy         out  1             high while a write sequence (SETUP/STROBE/HOLD) is in progress
// - Overrun      out  1             sticky: a data byte completed while Busy and was dropped
// BEHAVIOUR
// - Reset (async, _RST low): _Write=1, AddressBus=0, DataIn=0, Busy=0, Overrun=0, FSM=IDLE, bit counter=0; outputs change immediately, no clock needed.
// - Reset asserted mid-strobe releases _Write high at once; no register capture results, since capture is on _Write falling edge.
// - SCK, MOSI, CS_n each pass through a 2-flop synchronizer; SCK rising edge is detected on synchronized samples; MOSI is sampled on that edge.
// - Requirement: CLK >= 8 x SCK frequency; byte period must exceed StrobeCycles+2 CLK cycles.
// - Bit counter counts 0..7 on each SCK rise while CS_n low; at 8th bit the byte is complete and the counter wraps to 0.
// - Frame FSM (receive side):
//   - IDLE: CS_n falling -> ADDR; Overrun cleared here.
//   - ADDR: byte complete -> address pointer <= byte[AddressWidth-1:0] -> DATA.
//   - DATA: byte complete -> issue write of (pointer, byte) -> stay in DATA.
//   - Any state: CS_n high -> IDLE; partial byte discarded, bit counter cleared.
// - Write FSM (bus side), started by a DATA byte complete:
//   - SETUP: 1 cycle; drive AddressBus/DataIn; _Write=1; Busy=1.
//   - STROBE: StrobeCycles cycles; _Write=0.
//   - HOLD: 1 cycle; _Write=1; AddressBus/DataIn unchanged -> back to idle, Busy=0.
// - Latency: first SETUP cycle begins 1 CLK after the synchronized 8th SCK rise of the data byte.
// - AddressBus/DataIn keep their last values after HOLD until the next SETUP.
// - Byte completes while Busy: byte dropped, Overrun=1 (sticky until next CS_n fall or reset); the pointer is not advanced.
// - CS_n rising during SETUP/STROBE/HOLD: the write in progress completes normally.
// - Frame with address byte only, or CS_n high before byte 0 completes: no write issued.
// CONFIGURATION
// - AUTO_INCREMENT_EN defined: pointer increments by 1 after each issued write, wrapping 2^AddressWidth-1 -> 0; multi-byte frames fill consecutive registers.
// - AUTO_INCREMENT_EN undefined: pointer is fixed for the frame; every data byte rewrites the same address.
// TESTING
// - Reset: hold _RST low with SPI activity -> _Write=1, AddressBus=0, DataIn=0, Busy=0, Overrun=0 throughout.
// - Single write: frame 0x02,0xA5 -> exactly one _Write low pulse of StrobeCycles cycles, AddressBus=0x02 and DataIn=0xA5 stable from 1 cycle before the fall to 1 cycle after the rise.
// - Burst (AUTO_INCREMENT_EN): frame 0x00,0x11,0x22,0x33 -> writes (0x00,0x11),(0x01,0x22),(0x02,0x33); without the macro all three target 0x00.
// - Wrap: AUTO_INCREMENT_EN, frame 0xFF,0x5A,0x6B -> writes (0xFF,0x5A),(0x00,0x6B).
// - Abort: frame 0x03 then 5 bits, CS_n high -> no write; next frame 0x04,0x77 -> single write (0x04,0x77).
// - Overrun: SCK at CLK/2, so the byte period is shorter than StrobeCycles+2 -> second byte dropped, Overrun=1; cleared on next CS_n fall.

Source files
------------

// File: rtl/spi_register_bridge.sv
// SPI mode-0 slave that turns address/data byte frames into CLK-synchronous register writes.
// Optional AUTO_INCREMENT_EN: the write pointer advances after every issued write.
module spi_register_bridge #(
   parameter int AddressWidth = 8,
   parameter int BitWidth     = 8,
   parameter int StrobeCycles = 2
) (
   input  logic                    CLK,
   input  logic                    _RST,
   input  logic                    SCK,
   input  logic                    MOSI,
   input  logic                    CS_n,
   output logic                    _Write,
   output logic [AddressWidth-1:0] AddressBus,
   output logic [BitWidth-1:0]     DataIn,
   output logic                    Busy,
   output logic                    Overrun
);

   localparam int CountWidth = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

   typedef enum logic [1:0] {FrameIdle, FrameAddr, FrameData} frameStateT;
   typedef enum logic [1:0] {WriteIdle, WriteSetup, WriteStrobe, WriteHold} writeStateT;

   frameStateT frameState, frameNext;
   writeStateT writeState, writeNext;

   logic [1:0]              sckSync, mosiSync, csSync;
   logic                    sckPrev, csPrev;
   logic                    sckRise, csHigh, csFall;
   logic [2:0]              bitCount;
   logic [7:0]              shiftReg, byteValue;
   logic                    byteComplete, issueWrite, dropByte;
   logic [AddressWidth-1:0] pointer;
   logic [CountWidth-1:0]   strobeCount;

   // CS_n synchronizer resets to the deselected level so reset does not fake a frame start
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         sckSync  <= 2'b00;
         sckPrev  <= 1'b0;
         mosiSync <= 2'b00;
         csSync   <= 2'b11;
         csPrev   <= 1'b1;
      end else begin
         sckSync  <= {sckSync[0], SCK};
         sckPrev  <= sckSync[1];
         mosiSync <= {mosiSync[0], MOSI};
         csSync   <= {csSync[0], CS_n};
         csPrev   <= csSync[1];
      end
   end

   assign sckRise      = sckSync[1] & ~sckPrev;
   assign csHigh       = csSync[1];
   assign csFall       = ~csSync[1] & csPrev;
   assign byteValue    = {shiftReg[6:0], mosiSync[1]};
   assign byteComplete = sckRise & ~csHigh & (bitCount == 3'd7);

   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         bitCount <= 3'd0;
         shiftReg <= 8'h00;
      end else if (csHigh) begin
         bitCount <= 3'd0;
      end else if (sckRise) begin
         shiftReg <= byteValue;
         bitCount <= bitCount + 3'd1;
      end
   end

   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) frameState <= FrameIdle;
      else       frameState <= frameNext;
   end

   always_comb begin
      frameNext = frameState;
      if (csHigh) begin
         frameNext = FrameIdle;
      end else begin
         case (frameState)
            FrameIdle: if (csFall)       frameNext = FrameAddr;
            FrameAddr: if (byteComplete) frameNext = FrameData;
            FrameData: frameNext = FrameData;
            default:   frameNext = FrameIdle;
         endcase
      end
   end

   assign issueWrite = (frameState == FrameData) & byteComplete & (writeState == WriteIdle);
   assign dropByte   = (frameState == FrameData) & byteComplete & (writeState != WriteIdle);

   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         pointer <= '0;
      end else if ((frameState == FrameAddr) && byteComplete) begin
         pointer <= byteValue[AddressWidth-1:0];
`ifdef AUTO_INCREMENT_EN
      end else if (issueWrite) begin
         pointer <= pointer + AddressWidth'(1);
`endif
      end
   end

   // Overrun is sticky across the frame and only a new chip-select fall clears it
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST)                               Overrun <= 1'b0;
      else if (frameState == FrameIdle && csFall) Overrun <= 1'b0;
      else if (dropByte)                       Overrun <= 1'b1;
   end

   always_comb begin
      writeNext = writeState;
      case (writeState)
         WriteIdle:   if (issueWrite) writeNext = WriteSetup;
         WriteSetup:  writeNext = WriteStrobe;
         WriteStrobe: if (strobeCount == CountWidth'(StrobeCycles - 1)) writeNext = WriteHold;
         WriteHold:   writeNext = WriteIdle;
         default:     writeNext = WriteIdle;
      endcase
   end

   // Strobe and busy are registered from the next state so the bus sees glitch-free edges
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         writeState  <= WriteIdle;
         strobeCount <= '0;
         _Write      <= 1'b1;
         Busy        <= 1'b0;
         AddressBus  <= '0;
         DataIn      <= '0;
      end else begin
         writeState <= writeNext;
         _Write     <= (writeNext != WriteStrobe);
         Busy       <= (writeNext != WriteIdle);
         if (writeState == WriteStrobe) strobeCount <= strobeCount + CountWidth'(1);
         else                           strobeCount <= '0;
         if (issueWrite) begin
            AddressBus <= pointer;
            DataIn     <= byteValue;
         end
      end
   end

endmodule

// File: tb/tb_spi_register_bridge.sv
// Scoreboard bench for spi_register_bridge: SPI frames push expected writes, a bus monitor pops and checks them.
module tb_spi_register_bridge;

   // A long strobe lets an SCK of CLK/2 complete a byte while the previous write is still busy
   localparam int TbStrobe = 16;

   logic       CLK = 0;
   logic       _RST = 1;
   logic       SCK = 0;
   logic       MOSI = 0;
   logic       CS_n = 1;
   logic       _Write;
   logic [7:0] AddressBus;
   logic [7:0] DataIn;
   logic       Busy;
   logic       Overrun;

   int          checkCount = 0;
   int          errorCount = 0;
   logic [15:0] expQ[$];
   logic [7:0]  frameQ[$];

   spi_register_bridge #(
      .AddressWidth(8),
      .BitWidth(8),
      .StrobeCycles(TbStrobe)
   ) dut (
      .CLK(CLK),
      ._RST(_RST),
      .SCK(SCK),
      .MOSI(MOSI),
      .CS_n(CS_n),
      ._Write(_Write),
      .AddressBus(AddressBus),
      .DataIn(DataIn),
      .Busy(Busy),
      .Overrun(Overrun)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_Write"}, _Write, 1);
      checkOutput({tag, "Addr"}, AddressBus, 0);
      checkOutput({tag, "Data"}, DataIn, 0);
      checkOutput({tag, "Busy"}, Busy, 0);
      checkOutput({tag, "Overrun"}, Overrun, 0);
   endtask

   task automatic sendBits(input logic [7:0] value, input int nBits, input int half);
      for (int i = 7; i > 7 - nBits; i--) begin
         MOSI = value[i];
         SCK  = 0;
         repeat (half) @(negedge CLK);
         SCK = 1;
         repeat (half) @(negedge CLK);
      end
      SCK = 0;
   endtask

   task automatic csLow();
      @(negedge CLK);
      CS_n = 0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic csRelease();
      repeat (4) @(negedge CLK);
      CS_n = 1;
      repeat (TbStrobe + 20) @(negedge CLK);
   endtask

   // Sends frameQ; the first keepCount data bytes are expected as writes, the rest dropped
   task automatic applyStimulus(input int half, input int keepCount, input int extraBits);
      int ptr;
      int kept;
      ptr  = 0;
      kept = 0;
      csLow();
      for (int i = 0; i < frameQ.size(); i++) begin
         if (i == 0) begin
            ptr = int'(frameQ[0]);
         end else if (kept < keepCount) begin
            expQ.push_back({ptr[7:0], frameQ[i]});
            kept++;
`ifdef AUTO_INCREMENT_EN
            ptr = (ptr + 1) % 256;
`endif
         end
         sendBits(frameQ[i], 8, half);
      end
      if (extraBits > 0) sendBits(8'hFF, extraBits, half);
      csRelease();
   endtask

   logic        prevWrite = 1;
   logic [7:0]  prevAddr = 0;
   logic [7:0]  prevData = 0;
   logic [15:0] lastExp = 0;
   int          lowCount = 0;

   always @(negedge CLK) begin
      if (!_RST) begin
         prevWrite = 1;
         lowCount  = 0;
      end else begin
         if (prevWrite && !_Write) begin
            checkOutput("writeExpected", expQ.size() > 0, 1);
            if (expQ.size() > 0) begin
               lastExp = expQ.pop_front();
               checkOutput("addrAtFall", AddressBus, lastExp[15:8]);
               checkOutput("dataAtFall", DataIn, lastExp[7:0]);
               checkOutput("addrSetup", prevAddr, lastExp[15:8]);
               checkOutput("dataSetup", prevData, lastExp[7:0]);
               checkOutput("busyAtFall", Busy, 1);
            end
            lowCount = 1;
         end else if (!_Write) begin
            lowCount++;
         end else if (!prevWrite) begin
            checkOutput("strobeLen", lowCount, TbStrobe);
            checkOutput("addrHold", AddressBus, lastExp[15:8]);
            checkOutput("dataHold", DataIn, lastExp[7:0]);
            checkOutput("busyHold", Busy, 1);
         end
         prevWrite = _Write;
      end
      prevAddr = AddressBus;
      prevData = DataIn;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checkCount, errorCount);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      #3 _RST = 0;
      #1 checkResetOutputs("asyncReset");

      fork
         begin
            @(negedge CLK);
            CS_n = 0;
            repeat (4) @(negedge CLK);
            sendBits(8'h02, 8, 2);
            sendBits(8'hA5, 8, 2);
            CS_n = 1;
         end
         begin
            repeat (8) begin
               repeat (5) @(negedge CLK);
               checkResetOutputs("heldReset");
            end
         end
      join
      @(negedge CLK);
      _RST = 1;
      repeat (5) @(negedge CLK);
      checkResetOutputs("afterRelease");

      $display("[TB] single write");
      frameQ.delete();
      frameQ.push_back(8'h02); frameQ.push_back(8'hA5);
      applyStimulus(8, 99, 0);
      checkOutput("singlePending", expQ.size(), 0);
      checkOutput("singleIdleBusy", Busy, 0);

      $display("[TB] burst");
      frameQ.delete();
      frameQ.push_back(8'h00); frameQ.push_back(8'h11);
      frameQ.push_back(8'h22); frameQ.push_back(8'h33);
      applyStimulus(8, 99, 0);
      checkOutput("burstPending", expQ.size(), 0);
      checkOutput("burstLastAddrKept", AddressBus, lastExp[15:8]);
      checkOutput("burstLastDataKept", DataIn, 8'h33);

      $display("[TB] wrap");
      frameQ.delete();
      frameQ.push_back(8'hFF); frameQ.push_back(8'h5A); frameQ.push_back(8'h6B);
      applyStimulus(8, 99, 0);
      checkOutput("wrapPending", expQ.size(), 0);

      $display("[TB] abort then recover");
      frameQ.delete();
      frameQ.push_back(8'h03);
      applyStimulus(8, 99, 5);
      checkOutput("abortDataKept", DataIn, 8'h6B);
      frameQ.delete();
      frameQ.push_back(8'h04); frameQ.push_back(8'h77);
      applyStimulus(8, 99, 0);
      checkOutput("recoverPending", expQ.size(), 0);

      $display("[TB] overrun");
      checkOutput("overrunIdle", Overrun, 0);
      frameQ.delete();
      frameQ.push_back(8'h10); frameQ.push_back(8'h01); frameQ.push_back(8'h02);
      applyStimulus(1, 1, 0);
      checkOutput("overrunSet", Overrun, 1);
      checkOutput("overrunDataKept", DataIn, 8'h01);
      checkOutput("overrunPending", expQ.size(), 0);
      csLow();
      checkOutput("overrunCleared", Overrun, 0);
      csRelease();

      $display("[TB] reset during strobe");
      frameQ.delete();
      frameQ.push_back(8'h06); frameQ.push_back(8'h3C);
      fork
         applyStimulus(8, 99, 0);
         begin
            for (int i = 0; i < 600 && _Write !== 1'b0; i++) @(negedge CLK);
            checkOutput("midStrobeSeen", _Write, 0);
            #2 _RST = 0;
            #1 checkResetOutputs("midStrobe");
            repeat (3) @(negedge CLK);
            _RST = 1;
         end
      join
      checkOutput("midStrobePending", expQ.size(), 0);
      checkOutput("midStrobeWriteHigh", _Write, 1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
